axi_sram_slave: RTL

- AXI3 single-beat responder that lets the CPU-side AXI master reach a single-port synchronous SRAM.
- Accepts AR/AW/W requests, arbitrates them onto one RAM port, and returns R/B responses with the request ID echoed.
- Sits between the AXI interconnect (or the master bridge directly) and the instruction/data RAM macro in the SoC top.

---
 rtl/axi_sram_slave.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
//
// Single-beat AXI3 responder for one single-port synchronous SRAM. It accepts
// one read (AR) and one write (AW + W) at a time, places both on the RAM port
// (a write wins a same-cycle conflict), and returns R/B responses that echo the
// request ID.
//
// Ports
//   aclk, reset        clock, synchronous active-high reset
//   ar*                read request: id, byte address, len (ignored), valid/ready
//   r*                 read response: id, data, resp (OKAY), last, valid/ready
//   aw*                write address: id, byte address, len (ignored), valid/ready
//   w*                 write data: data, byte strobes, valid/ready
//   b*                 write response: id, resp (OKAY), valid/ready
//   ram_*              SRAM port: enable, byte write enables, word address,
//                      write data, read data (valid the cycle after a read)
// -----------------------------------------------------------------------------
module axi_sram_slave #(
    parameter int ADDR_W = 16
) (
    input  logic              aclk,
    input  logic              reset,
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_RAM  = 2'd1,
        R_CAP  = 2'd2,
        R_RESP = 2'd3
    } r_state_t;

    typedef enum logic [1:0] {
        W_COLLECT = 2'd0,
        W_RAM     = 2'd1,
        W_RESP    = 2'd2
    } w_state_t;

    r_state_t          r_state_r;
    r_state_t          r_state_s;
    w_state_t          w_state_r;
    w_state_t          w_state_s;

    logic [3:0]        rid_r;
    logic [ADDR_W-1:0] raddr_r;
    logic [31:0]       rdata_r;

    logic              aw_got_r;
    logic              w_got_r;
    logic [3:0]        bid_r;
    logic [ADDR_W-1:0] waddr_r;
    logic [31:0]       wdata_r;
    logic [3:0]        wstrb_r;

    logic              arready_s;
    logic              awready_s;
    logic              wready_s;
    logic              ar_hs_s;
    logic              aw_hs_s;
    logic              w_hs_s;
    logic              w_grant_s;
    logic              r_grant_s;

    // Burst length and the sub-word / out-of-range address bits carry no
    // meaning here: the address space wraps and wstrb alone selects bytes.
    logic              unused_s;
    assign unused_s = ^{arlen, awlen,
                        araddr[31:ADDR_W+2], araddr[1:0],
                        awaddr[31:ADDR_W+2], awaddr[1:0]};

    // Ready signals are forced low during reset so no handshake can start.
    assign arready_s = (r_state_r == R_IDLE) & ~reset;
    assign awready_s = (w_state_r == W_COLLECT) & ~aw_got_r & ~reset;
    assign wready_s  = (w_state_r == W_COLLECT) & ~w_got_r & ~reset;

    assign ar_hs_s = arvalid & arready_s;
    assign aw_hs_s = awvalid & awready_s;
    assign w_hs_s  = wvalid & wready_s;

    // The write side always owns the port when it asks; this keeps a read
    // issued in the same cycle as a write to the same word ordered after it.
    assign w_grant_s = (w_state_r == W_RAM) & ~reset;
    assign r_grant_s = (r_state_r == R_RAM) & ~w_grant_s & ~reset;

    // Read FSM next-state logic
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) r_state_s = R_RAM;
                else         r_state_s = R_IDLE;
            end
            R_RAM: begin
                if (r_grant_s) r_state_s = R_CAP;
                else           r_state_s = R_RAM;
            end
            R_CAP: begin
                r_state_s = R_RESP;
            end
            R_RESP: begin
                if (rready) r_state_s = R_IDLE;
                else        r_state_s = R_RESP;
            end
            default: begin
                r_state_s = R_IDLE;
            end
        endcase
    end

    // Write FSM next-state logic; AW and W may complete in either order or together
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_COLLECT: begin
                if ((aw_got_r | aw_hs_s) & (w_got_r | w_hs_s)) w_state_s = W_RAM;
                else                                           w_state_s = W_COLLECT;
            end
            W_RAM: begin
                if (w_grant_s) w_state_s = W_RESP;
                else           w_state_s = W_RAM;
            end
            W_RESP: begin
                if (bready) w_state_s = W_COLLECT;
                else        w_state_s = W_RESP;
            end
            default: begin
                w_state_s = W_COLLECT;
            end
        endcase
    end

    // Read FSM state, latched request fields and captured RAM data
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state_r <= R_IDLE;
            rid_r     <= 4'd0;
            raddr_r   <= {ADDR_W{1'b0}};
            rdata_r   <= 32'd0;
        end else begin
            r_state_r <= r_state_s;
            if (ar_hs_s) begin
                rid_r   <= arid;
                raddr_r <= araddr[ADDR_W+1:2];
            end
            if (r_state_r == R_CAP) begin
                rdata_r <= ram_rdata;
            end
        end
    end

    // Write FSM state, per-channel got flags and latched write fields
    always_ff @(posedge aclk) begin
        if (reset) begin
            w_state_r <= W_COLLECT;
            aw_got_r  <= 1'b0;
            w_got_r   <= 1'b0;
            bid_r     <= 4'd0;
            waddr_r   <= {ADDR_W{1'b0}};
            wdata_r   <= 32'd0;
            wstrb_r   <= 4'd0;
        end else begin
            w_state_r <= w_state_s;
            if (aw_hs_s) begin
                bid_r   <= awid;
                waddr_r <= awaddr[ADDR_W+1:2];
            end
            if (w_hs_s) begin
                wdata_r <= wdata;
                wstrb_r <= wstrb;
            end
            if (w_grant_s) begin
                aw_got_r <= 1'b0;
                w_got_r  <= 1'b0;
            end else begin
                if (aw_hs_s) aw_got_r <= 1'b1;
                if (w_hs_s)  w_got_r  <= 1'b1;
            end
        end
    end

    // AXI outputs; every one reads as zero while reset is high
    assign arready = arready_s;
    assign awready = awready_s;
    assign wready  = wready_s;
    assign rvalid  = (r_state_r == R_RESP) & ~reset;
    assign rlast   = rvalid;
    assign rid     = reset ? 4'd0 : rid_r;
    assign rdata   = reset ? 32'd0 : rdata_r;
    assign rresp   = 2'b00;
    assign bvalid  = (w_state_r == W_RESP) & ~reset;
    assign bid     = reset ? 4'd0 : bid_r;
    assign bresp   = 2'b00;

    // RAM port mux: address and data stay zero on idle cycles
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'd0;
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = 32'd0;
        if (w_grant_s) begin
            ram_en    = 1'b1;
            ram_we    = wstrb_r;
            ram_addr  = waddr_r;
            ram_wdata = wdata_r;
        end else if (r_grant_s) begin
            ram_en    = 1'b1;
            ram_addr  = raddr_r;
        end else begin
            ram_en    = 1'b0;
        end
    end

endmodule
